// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the mac_stream multiply-accumulate engine:
//   - default widths (DATA_W_DEF, ACC_W_DEF, LEN_W_DEF)
//   - accumulation state enum (FIRST / ACCUM)
//   - sat_add(): ACC_W-wide add with overflow detection. Behaviour on overflow
//     depends on the macro MAC_SATURATE_EN:
//       defined   -> the sum clamps to the signed/unsigned limit
//       undefined -> the sum wraps modulo 2^w; ovf still reports the wrap
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 36;
  localparam int LEN_W_DEF  = 8;

  // sat_add works on a fixed wide container so one function serves any ACC_W;
  // the live width is passed in and must be below this bound.
  localparam int MAX_ACC_W = 128;
  localparam int MSB_W     = $clog2(MAX_ACC_W);

  typedef enum logic {
    FIRST = 1'b0,  // next S3 term starts a new sum
    ACCUM = 1'b1   // next S3 term adds onto the running sum
  } state_t;

  typedef struct packed {
    logic [MAX_ACC_W-1:0] sum;
    logic                 ovf;
  } add_t;

  // Adds the low w bits of x and y. Signed overflow is a sign flip between two
  // same-signed operands; unsigned overflow is the carry out of bit w-1.
  function automatic add_t sat_add(input logic [MAX_ACC_W-1:0] x,
                                   input logic [MAX_ACC_W-1:0] y,
                                   input logic                 sgn,
                                   input int unsigned          w);
    logic [MAX_ACC_W-1:0] mask;
    logic [MAX_ACC_W-1:0] smax;
    logic [MAX_ACC_W-1:0] xm;
    logic [MAX_ACC_W-1:0] ym;
    logic [MSB_W-1:0]     msb;
    add_t                 r;
    mask  = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - w);
    smax  = mask >> 1;
    xm    = x & mask;
    ym    = y & mask;
    msb   = MSB_W'(w - 1);
    r.sum = (xm + ym) & mask;
    if (sgn) r.ovf = (xm[msb] == ym[msb]) && (r.sum[msb] != xm[msb]);
    else     r.ovf = (r.sum < xm);  // wrapped below an operand => carry out
`ifdef MAC_SATURATE_EN
    if (r.ovf) begin
      if (!sgn)        r.sum = mask;           // 2^w - 1
      else if (xm[msb]) r.sum = mask & ~smax;  // -2^(w-1)
      else             r.sum = smax;           // 2^(w-1) - 1
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/mac_stream_if.sv
// -----------------------------------------------------------------------------
// mac_stream_if
// Operand stream, clear and result port of mac_stream bundled as one interface.
//   master : producer/consumer side (drives operands, clear, res_ready)
//   slave  : the MAC engine (drives in_ready and the held result)
// Signals: clear, in_valid, in_ready, a, b, in_signed, in_last,
//          res_valid, res_ready, res_data, res_count, res_ovf
// -----------------------------------------------------------------------------
interface mac_stream_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              in_signed;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [LEN_W-1:0]  res_count;
  logic              res_ovf;

  modport master (
    output clear, in_valid, a, b, in_signed, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_count, res_ovf
  );

  modport slave (
    input  clear, in_valid, a, b, in_signed, in_last, res_ready,
    output in_ready, res_valid, res_data, res_count, res_ovf
  );

endinterface

// File: rtl/mac_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mult_stage
// Pipeline stages S1 (operand register) and S2 (registered product) of the MAC.
// Ports:
//   clk, reset            clock, async active-high reset
//   en                    advance both stages (low = hold everything)
//   flush                 drop both stage valids, even while held
//   in_valid/a/b/in_signed/in_last   accepted term
//   out_valid/out_prod/out_signed/out_last  S2 term, product is 2*DATA_W bits
// -----------------------------------------------------------------------------
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                in_signed,
  input  logic                in_last,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] out_prod,
  output logic                out_signed,
  output logic                out_last
);

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_a;
  logic [DATA_W-1:0]   s1_b;
  logic                s1_signed;
  logic                s1_last;
  logic [2*DATA_W-1:0] ax;
  logic [2*DATA_W-1:0] bx;
  logic [2*DATA_W-1:0] prod;

  // Extending both operands to the full product width makes the low 2*DATA_W
  // bits of a plain multiply correct for both signed and unsigned terms.
  assign ax   = {{DATA_W{s1_signed & s1_a[DATA_W-1]}}, s1_a};
  assign bx   = {{DATA_W{s1_signed & s1_b[DATA_W-1]}}, s1_b};
  assign prod = ax * bx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage order inside the block cannot matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed when the
  // matching valid is set, so resetting them would only cost reset routing.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a       <= a;
      s1_b       <= b;
      s1_signed  <= in_signed;
      s1_last    <= in_last;
      out_prod   <= prod;
      out_signed <= s1_signed;
      out_last   <= s1_last;
    end
  end

endmodule

// File: rtl/mac_stream.sv
// -----------------------------------------------------------------------------
// mac_stream
// Pipelined multiply-accumulate engine. Accepts one operand pair per cycle,
// sums products over a dot product delimited by in_last and presents each
// finished sum, term count and overflow flag on a result port held until
// res_ready. Last term accepted in cycle t -> res_valid in cycle t+3.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   bus    mac_stream_if.slave (operand stream, clear, result port)
// Option: define MAC_SATURATE_EN to clamp the accumulator on overflow instead
//         of wrapping (see mac_pkg::sat_add).
// -----------------------------------------------------------------------------
module mac_stream
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mac_stream_if.slave  bus
);

  if (ACC_W < 2*DATA_W || ACC_W >= MAX_ACC_W) begin : g_bad_cfg
    $error("mac_stream: ACC_W must be >= 2*DATA_W and < %0d", MAX_ACC_W);
  end

  logic                stall;
  logic                accept;
  logic                s3_fire;
  logic                s2_valid;
  logic [2*DATA_W-1:0] s2_prod;
  logic                s2_signed;
  logic                s2_last;
  state_t              state;
  state_t              state_d;
  logic                start_sum;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    base;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    sum;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    base_cnt;
  logic [LEN_W-1:0]    cnt_inc;
  logic                ovf_acc;
  logic                ovf_new;
  add_t                add_r;
  logic                unused_hi;

  // A held, unconsumed result freezes the whole pipeline.
  assign stall        = bus.res_valid && !bus.res_ready;
  assign bus.in_ready = !stall && !bus.clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s3_fire      = s2_valid && !stall && !bus.clear;

  mac_mult_stage #(.DATA_W(DATA_W)) u_mult (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall),
    .flush      (bus.clear),
    .in_valid   (accept),
    .a          (bus.a),
    .b          (bus.b),
    .in_signed  (bus.in_signed),
    .in_last    (bus.in_last),
    .out_valid  (s2_valid),
    .out_prod   (s2_prod),
    .out_signed (s2_signed),
    .out_last   (s2_last)
  );

  // ---- FSM: state register / next state / outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FIRST;
    else       state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    if (bus.clear)    state_d = FIRST;
    else if (s3_fire) state_d = s2_last ? FIRST : ACCUM;
  end

  always_comb begin
    start_sum = (state == FIRST);
  end

  // ---- S3 datapath ----
  always_comb begin
    prod_ext = s2_signed ? ACC_W'($signed(s2_prod)) : ACC_W'(s2_prod);
    base     = start_sum ? '0 : acc;
    base_cnt = start_sum ? '0 : cnt;
    cnt_inc  = (&base_cnt) ? base_cnt : base_cnt + LEN_W'(1);
    add_r    = sat_add(MAX_ACC_W'(base), MAX_ACC_W'(prod_ext), s2_signed, ACC_W);
    sum      = add_r.sum[ACC_W-1:0];
    ovf_new  = (!start_sum && ovf_acc) || add_r.ovf;
  end

  assign unused_hi = ^add_r.sum[MAX_ACC_W-1:ACC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (bus.clear) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (s3_fire) begin
      acc     <= sum;
      cnt     <= cnt_inc;
      ovf_acc <= ovf_new;
    end
  end

  // Result port: a finishing sum always reloads it (s3_fire implies the old
  // result is consumed this cycle or absent), otherwise res_ready retires it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_count <= '0;
      bus.res_ovf   <= 1'b0;
    end else if (s3_fire && s2_last) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= sum;
      bus.res_count <= cnt_inc;
      bus.res_ovf   <= ovf_new;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// -----------------------------------------------------------------------------
// tb_mac_stream
// Self-checking bench for mac_stream. A reference model computes each dot
// product as terms are accepted and pushes the expected result onto a queue;
// a monitor pops and compares whenever a result is handed over.
// Honours MAC_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mac_stream;

  localparam int DW = 16;
  localparam int AW = 36;
  localparam int LW = 8;

  localparam longint MODU = longint'(1) << AW;
  localparam longint MAXU = MODU - 1;
  localparam longint MAXS = (MODU >> 1) - 1;
  localparam longint MINS = -(MODU >> 1);
  localparam int     CMAX = (1 << LW) - 1;

  typedef struct packed {
    logic [AW-1:0] data;
    logic [LW-1:0] count;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_stream_if #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) bus ();

  mac_stream #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  res_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_val    = 0;
  int     m_cnt    = 0;
  logic   m_ovf    = 1'b0;
  bit     m_first  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: exact arithmetic in 64 bits, then wrap or clamp to AW.
  task automatic model_term(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sgn, input logic last);
    longint p;
    longint s;
    if (m_first) begin
      m_val = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'(a) * longint'(b);
    s = m_val + p;
    if (sgn) begin
      if (s > MAXS || s < MINS) begin
        m_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
        s = (s > MAXS) ? MAXS : MINS;
`else
        s = (s > MAXS) ? s - MODU : s + MODU;
`endif
      end
    end else if (s > MAXU) begin
      m_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
      s = MAXU;
`else
      s = s - MODU;
`endif
    end
    m_val = s;
    if (m_cnt < CMAX) m_cnt++;
    if (last) begin
      exp_q.push_back('{data: AW'(m_val), count: LW'(m_cnt), ovf: m_ovf});
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
    end
  endtask

  // Presents one term and returns #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic sgn, input logic last);
    bit ok = 1'b0;
    bus.a         = a;
    bus.b         = b;
    bus.in_signed = sgn;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (ok) model_term(a, b, sgn, last);
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is handed over at the edge after a negedge that sees
  // res_valid && res_ready.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.res_valid && bus.res_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_data",  64'(bus.res_data),  64'(e.data));
          check("res_count", 64'(bus.res_count), 64'(e.count));
          check("res_ovf",   64'(bus.res_ovf),   64'(e.ovf));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_signed = 1'b0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data",  64'(bus.res_data),  64'd0);
    check("rst_res_count", 64'(bus.res_count), 64'd0);
    check("rst_res_ovf",   64'(bus.res_ovf),   64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // Unsigned 3-term dot product, latency t+3
    send(16'd3, 16'd4, 1'b0, 1'b0);
    send(16'd5, 16'd6, 1'b0, 1'b0);
    send(16'd7, 16'd8, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_s2_valid", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    check("lat_s3_valid", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    check("lat_res_valid", 64'(bus.res_valid), 64'd1);
    check("dot3_data",     64'(bus.res_data),  64'd98);
    check("dot3_count",    64'(bus.res_count), 64'd3);
    drain();

    // Signed single term -2 * 3
    send(16'hFFFE, 16'd3, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("sgn1_data",  64'(bus.res_data),  64'h0000000FFFFFFFFA);
    check("sgn1_count", 64'(bus.res_count), 64'd1);
    drain();

    // Back-pressure: two sums queued while res_ready is low
    bus.res_ready = 1'b0;
    send(16'd1, 16'd2, 1'b0, 1'b0);
    send(16'd3, 16'd4, 1'b0, 1'b1);
    send(16'd2, 16'd2, 1'b0, 1'b1);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready",  64'(bus.in_ready),  64'd0);
      check("stall_res_valid", 64'(bus.res_valid), 64'd1);
      check("stall_res_data",  64'(bus.res_data),  64'd14);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    send(16'd5, 16'd5, 1'b0, 1'b1);
    drain();

    // Unsigned overflow: 32 x 0xFFFF*0xFFFF
    for (int i = 0; i < 32; i++) send(16'hFFFF, 16'hFFFF, 1'b0, i == 31);
    drain();

    // Signed overflow: 32 x (-32768)^2 crosses 2^35 on the last term
    for (int i = 0; i < 32; i++) send(16'h8000, 16'h8000, 1'b1, i == 31);
    drain();

    // Term counter saturation: 260 x (1*1)
    for (int i = 0; i < 260; i++) send(16'd1, 16'd1, 1'b0, i == 259);
    drain();

    // clear after 2 of 4 terms; clear beats a simultaneous in_valid
    send(16'd2, 16'd3, 1'b0, 1'b0);
    send(16'd4, 16'd5, 1'b0, 1'b0);
    bus.clear    = 1'b1;
    bus.a        = 16'd9;
    bus.b        = 16'd9;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("clr_in_ready",  64'(bus.in_ready),  64'd0);
    check("clr_res_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    m_first      = 1'b1;
    send(16'd1, 16'd1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("clr_new_data",  64'(bus.res_data),  64'd1);
    check("clr_new_count", 64'(bus.res_count), 64'd1);
    drain();

    // reset mid-sum with a held result
    bus.res_ready = 1'b0;
    send(16'd5, 16'd5, 1'b0, 1'b1);
    send(16'd2, 16'd2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", 64'(bus.res_valid), 64'd1);
    check("pre_rst_data",  64'(bus.res_data),  64'd25);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_data",  64'(bus.res_data),  64'd0);
    check("mid_rst_count", 64'(bus.res_count), 64'd0);
    check("mid_rst_ovf",   64'(bus.res_ovf),   64'd0);
    exp_q.delete();
    m_first = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.res_ready = 1'b1;
    send(16'd6, 16'd7, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("post_rst_data",  64'(bus.res_data),  64'd42);
    check("post_rst_count", 64'(bus.res_count), 64'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
